comp_debounce: RTL and testbench
================================

# comp_debounce

Sequential stage directly downstream of the N-bit magnitude comparator `comp`. It samples the comparator's `agb`/`aeb`/`alb` flags and requires DEB consecutive valid samples before committing a new relation state (EQ/GT/LT). It emits a one-cycle change pulse, an error pulse for malformed flag codes, and a saturating count of committed transitions. It turns a noisy or glitching compare result into a stable, registered decision for control logic.

## Interface
- `DEB`, default 4: consecutive qualifying samples needed to commit a new state; legal range ≥1.
- `CW`, default 8: width of the transition counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: the flags on this cycle are a sample; when low, all internal state holds.
- `agb` in 1: a > b flag from `comp`.
- `aeb` in 1: a == b flag from `comp`.
- `alb` in 1: a < b flag from `comp`.
- `cnt_clr` in 1: synchronous clear of `evt_cnt`.
- `state` out 2: committed relation; 2'b00 EQ, 2'b01 GT, 2'b10 LT.
- `chg` out 1: one-cycle pulse when `state` changes.
- `err` out 1: one-cycle pulse for an invalid sample.
- `evt_cnt` out CW: number of committed changes; saturates at all-ones.

## Operation
- The raw code is {agb,aeb,alb}. Valid codes are 100 (GT), 010 (EQ) and 001 (LT). Any other code is invalid.
- Internal registers:
  - `cand`: 2-bit candidate state.
  - `run`: width $clog2(DEB+1), counts consecutive matching samples.
- Per clock with `in_valid`=1:
  - Invalid code: `err`←1, `run`←0, `state` and `cand` unchanged.
  - Valid code equal to `state`: `run`←0. Any pending candidate is abandoned.
  - Valid code ≠ `state` and equal to `cand` with `run`>0: `run`←`run`+1.
  - Valid code ≠ `state`, otherwise: `cand`←code, `run`←1.
  - Commit: if the updated run value equals DEB, then `state`←code, `run`←0, `chg`←1, and `evt_cnt`←`evt_cnt`+1 unless it is all-ones.
- With DEB=1, every valid differing sample commits immediately.
- When `in_valid`=0: `run`, `cand` and `state` hold; `chg` and `err` are 0. A gap in samples does not break a run.
- `cnt_clr`=1 forces `evt_cnt`←0 on that edge. It wins over a simultaneous increment, and `chg` still pulses.
- A sample that alternates GT→LT before reaching DEB restarts the run at 1 with the new candidate.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: `state`, `chg` and `evt_cnt` update on the same rising edge that samples the DEB-th qualifying input. `chg` is high for exactly the following cycle.
- `err` is high for the cycle after the edge that sampled the invalid code.
- Reset values, applied asynchronously on `rst` rising and held while `rst`=1:
  - outputs: `state`=EQ, `chg`=0, `err`=0, `evt_cnt`=0;
  - internal: `cand`=EQ, `run`=0.
- Reset mid-run discards the partial run. After release, the first sample is evaluated from EQ.
- Saturation: at `evt_cnt`=2^CW−1 further commits still pulse `chg`, but the count stays at all-ones.

## Structure
- Shared package `comp_pkg`:
  - localparams `ST_EQ`=2'b00, `ST_GT`=2'b01, `ST_LT`=2'b10;
  - a flag-to-state decode function returning the state plus a valid bit.
- Sub-module `sat_cnt` (params W; inputs `clk`, `rst`, `inc`, `clr`; output `q`) implements `evt_cnt`. Clear priority is inside it.
- The top level holds the decode, the candidate/run logic and the state register.

## Test plan
- Reset, then 3 valid GT samples with DEB=4 → `state` stays 00 and `chg` never rises. The 4th GT sample → `state`=01, `chg` pulses one cycle, `evt_cnt`=1.
- With DEB=4 from EQ: GT,GT,LT,LT,LT,LT → no commit on the GT samples; commit to LT on the 6th sample, `evt_cnt`=1.
- Code 110, then 000, each with `in_valid`=1 → `err` pulses twice, `state` unchanged, and a 2-sample GT run in progress restarts from 0.
- GT,GT, then `in_valid`=0 for 5 cycles, then GT,GT with DEB=4 → commit to GT on the 4th valid sample.
- CW=2: 4 alternating commits (GT,EQ,GT,EQ) → `evt_cnt` reads 3 after the 3rd and 4th commits, with 4 `chg` pulses. Then `cnt_clr` together with a 5th commit → `evt_cnt`=0 and `chg`=1.
- Assert `rst` asynchronously after 2 GT samples (DEB=4) → outputs return to their reset values immediately. After release, 4 GT samples are needed to commit.

Source files
------------

// File: rtl/comp_pkg.sv
// comp_pkg: relation state encodings and flag decode shared by the comparator debounce logic.
package comp_pkg;
    localparam logic [1:0] ST_EQ = 2'b00;
    localparam logic [1:0] ST_GT = 2'b01;
    localparam logic [1:0] ST_LT = 2'b10;

    typedef struct packed {
        logic       vld;
        logic [1:0] st;
    } dec_t;

    // Exactly one flag must be set; anything else is a malformed sample.
    function automatic dec_t decode(input logic agb, input logic aeb, input logic alb);
        dec_t d;
        d.vld = ({agb, aeb, alb} == 3'b100) || ({agb, aeb, alb} == 3'b010) || ({agb, aeb, alb} == 3'b001);
        d.st  = agb ? ST_GT : alb ? ST_LT : ST_EQ;
        return d;
    endfunction
endpackage

// File: rtl/comp_debounce_sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear taking priority over increment.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d, q_q;

    always_comb q_d = clr ? '0 : (inc && q_q != '1) ? q_q + W'(1) : q_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= '0;
        else     q_q <= q_d;

    assign q = q_q;
endmodule

// File: rtl/comp_debounce.sv
// comp_debounce: debounces comp's agb/aeb/alb flags into a registered EQ/GT/LT decision.
// A new state commits after DEB consecutive matching samples; commits are counted.
module comp_debounce
    import comp_pkg::*;
#(
    parameter int DEB = 4,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          agb,
    input  logic          aeb,
    input  logic          alb,
    input  logic          cnt_clr,
    output logic [1:0]    state,
    output logic          chg,
    output logic          err,
    output logic [CW-1:0] evt_cnt
);
    localparam int RW = $clog2(DEB + 1);

    dec_t          dec;
    logic [1:0]    state_d, state_q, cand_d, cand_q;
    logic [RW-1:0] run_d, run_q, run_n;
    logic          chg_d, chg_q, err_d, err_q;

    assign dec = decode(agb, aeb, alb);

    // run never rests at DEB (a commit clears it), so run_n always fits in RW bits.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        chg_d   = 1'b0;
        err_d   = 1'b0;
        run_n   = (dec.st == cand_q && run_q != '0) ? run_q + RW'(1) : RW'(1);
        if (in_valid) begin
            if (!dec.vld) begin
                err_d = 1'b1;
                run_d = '0;
            end else if (dec.st == state_q) begin
                run_d = '0;
            end else if (run_n == RW'(DEB)) begin
                state_d = dec.st;
                cand_d  = dec.st;
                run_d   = '0;
                chg_d   = 1'b1;
            end else begin
                cand_d = dec.st;
                run_d  = run_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ST_EQ;
            cand_q  <= ST_EQ;
            run_q   <= '0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end

    sat_cnt #(.W(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (chg_d),
        .clr (cnt_clr),
        .q   (evt_cnt)
    );

    assign state = state_q;
    assign chg   = chg_q;
    assign err   = err_q;
endmodule

// File: tb/tb_comp_debounce.sv
// tb_comp_debounce: scoreboard bench driving a DEB=4/CW=2 and a DEB=1/CW=8 instance in parallel.
module tb_comp_debounce;
    localparam logic [2:0] C_GT = 3'b100, C_EQ = 3'b010, C_LT = 3'b001;

    typedef struct packed {
        logic [1:0] st;
        logic       chg;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, agb = 1'b0, aeb = 1'b0, alb = 1'b0, cnt_clr = 1'b0;
    logic [1:0] state0, state1;
    logic       chg0, chg1, err0, err1;
    logic [1:0] cnt0;
    logic [7:0] cnt1;

    int errors = 0, checks = 0;
    exp_t q0[$], q1[$];
    int m_state[2], m_cand[2], m_run[2], m_cnt[2];
    int deb[2] = '{4, 1};
    int cmax[2] = '{3, 255};

    always #5 clk = ~clk;

    comp_debounce #(.DEB(4), .CW(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agb(agb), .aeb(aeb), .alb(alb),
        .cnt_clr(cnt_clr), .state(state0), .chg(chg0), .err(err0), .evt_cnt(cnt0)
    );

    comp_debounce #(.DEB(1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agb(agb), .aeb(aeb), .alb(alb),
        .cnt_clr(cnt_clr), .state(state1), .chg(chg1), .err(err1), .evt_cnt(cnt1)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_cand[k]  = 0;
            m_run[k]   = 0;
            m_cnt[k]   = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model(input int k, input logic [2:0] code, input logic v, input logic clr);
        exp_t e;
        int c;
        logic ok;
        ok = (code == C_GT) || (code == C_EQ) || (code == C_LT);
        c = (code == C_GT) ? 1 : (code == C_LT) ? 2 : 0;
        e.chg = 1'b0;
        e.err = 1'b0;
        if (v) begin
            if (!ok) begin
                e.err = 1'b1;
                m_run[k] = 0;
            end else if (c == m_state[k]) begin
                m_run[k] = 0;
            end else begin
                if (c == m_cand[k] && m_run[k] > 0) m_run[k]++;
                else begin
                    m_cand[k] = c;
                    m_run[k] = 1;
                end
                if (m_run[k] == deb[k]) begin
                    m_state[k] = c;
                    m_run[k] = 0;
                    e.chg = 1'b1;
                    if (m_cnt[k] != cmax[k]) m_cnt[k]++;
                end
            end
        end
        if (clr) m_cnt[k] = 0;
        e.st  = 2'(m_state[k]);
        e.cnt = 8'(m_cnt[k]);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic step(input logic [2:0] code, input logic v, input logic clr);
        exp_t e;
        {agb, aeb, alb} = code;
        in_valid = v;
        cnt_clr = clr;
        model(0, code, v, clr);
        model(1, code, v, clr);
        @(posedge clk);
        #1;
        e = q0.pop_front();
        checks++;
        if ({state0, chg0, err0, 8'(cnt0)} !== e)
            begin errors++; $display("FAIL sb_deb4 code=%b v=%b: got st=%b chg=%b err=%b cnt=%0d, want st=%b chg=%b err=%b cnt=%0d",
                code, v, state0, chg0, err0, cnt0, e.st, e.chg, e.err, e.cnt); end
        e = q1.pop_front();
        checks++;
        if ({state1, chg1, err1, cnt1} !== e)
            begin errors++; $display("FAIL sb_deb1 code=%b v=%b: got st=%b chg=%b err=%b cnt=%0d, want st=%b chg=%b err=%b cnt=%0d",
                code, v, state1, chg1, err1, cnt1, e.st, e.chg, e.err, e.cnt); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state0, chg0, err0, cnt0} !== 6'b0) begin errors++; $display("FAIL reset: got %b want 000000", {state0, chg0, err0, cnt0}); end
        checks++;
        if ({state1, chg1, err1, cnt1} !== 12'b0) begin errors++; $display("FAIL reset1: got %b want 0", {state1, chg1, err1, cnt1}); end
    endtask

    task automatic test_commit();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(C_GT, 1'b1, 1'b0);
            checks++;
            if (state0 !== 2'b00 || chg0 !== 1'b0) begin errors++; $display("FAIL early_commit: st=%b chg=%b want 00 0", state0, chg0); end
        end
        checks++;
        if (state1 !== 2'b01) begin errors++; $display("FAIL deb1_commit: st=%b want 01", state1); end
        step(C_GT, 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b01 || chg0 !== 1'b1 || cnt0 !== 2'd1) begin errors++; $display("FAIL commit4: st=%b chg=%b cnt=%0d want 01 1 1", state0, chg0, cnt0); end
        step(C_GT, 1'b1, 1'b0);
        checks++;
        if (chg0 !== 1'b0) begin errors++; $display("FAIL chg_width: chg=%b want 0", chg0); end
    endtask

    task automatic test_alternate();
        logic [2:0] seq[6] = '{C_GT, C_GT, C_LT, C_LT, C_LT, C_LT};
        do_reset();
        for (int i = 0; i < 5; i++) step(seq[i], 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b00) begin errors++; $display("FAIL alt_early: st=%b want 00", state0); end
        step(seq[5], 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b10 || chg0 !== 1'b1 || cnt0 !== 2'd1) begin errors++; $display("FAIL alt_commit: st=%b chg=%b cnt=%0d want 10 1 1", state0, chg0, cnt0); end
    endtask

    task automatic test_invalid();
        do_reset();
        step(C_GT, 1'b1, 1'b0);
        step(C_GT, 1'b1, 1'b0);
        step(3'b110, 1'b1, 1'b0);
        checks++;
        if (err0 !== 1'b1 || state0 !== 2'b00) begin errors++; $display("FAIL err_110: err=%b st=%b want 1 00", err0, state0); end
        step(3'b000, 1'b1, 1'b0);
        checks++;
        if (err0 !== 1'b1) begin errors++; $display("FAIL err_000: err=%b want 1", err0); end
        for (int i = 0; i < 3; i++) step(C_GT, 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b00 || err0 !== 1'b0) begin errors++; $display("FAIL run_restart: st=%b err=%b want 00 0", state0, err0); end
        step(C_GT, 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b01) begin errors++; $display("FAIL inv_commit: st=%b want 01", state0); end
    endtask

    task automatic test_gap();
        do_reset();
        step(C_GT, 1'b1, 1'b0);
        step(C_GT, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step((i % 2) ? 3'b111 : C_LT, 1'b0, 1'b0);
        checks++;
        if (err0 !== 1'b0 || state0 !== 2'b00) begin errors++; $display("FAIL gap_hold: err=%b st=%b want 0 00", err0, state0); end
        step(C_GT, 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b00) begin errors++; $display("FAIL gap_early: st=%b want 00", state0); end
        step(C_GT, 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b01 || chg0 !== 1'b1) begin errors++; $display("FAIL gap_commit: st=%b chg=%b want 01 1", state0, chg0); end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                step((c % 2) ? C_EQ : C_GT, 1'b1, 1'b0);
                if (chg0) pulses++;
            end
            if (c >= 2) begin
                checks++;
                if (cnt0 !== 2'd3) begin errors++; $display("FAIL sat_cnt c=%0d: cnt=%0d want 3", c, cnt0); end
            end
        end
        checks++;
        if (pulses !== 4) begin errors++; $display("FAIL sat_pulses: got %0d want 4", pulses); end
        for (int i = 0; i < 3; i++) step(C_GT, 1'b1, 1'b0);
        step(C_GT, 1'b1, 1'b1);
        checks++;
        if (cnt0 !== 2'd0 || chg0 !== 1'b1) begin errors++; $display("FAIL clr_win: cnt=%0d chg=%b want 0 1", cnt0, chg0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(C_GT, 1'b1, 1'b0);
        step(C_LT, 1'b1, 1'b0);
        step(C_LT, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({state0, chg0, err0, cnt0} !== 6'b0 || {state1, chg1, err1, cnt1} !== 12'b0)
            begin errors++; $display("FAIL async_rst: got %b / %b want zeros", {state0, chg0, err0, cnt0}, {state1, chg1, err1, cnt1}); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(C_GT, 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b00) begin errors++; $display("FAIL post_rst_early: st=%b want 00", state0); end
        step(C_GT, 1'b1, 1'b0);
        checks++;
        if (state0 !== 2'b01 || cnt0 !== 2'd1) begin errors++; $display("FAIL post_rst_commit: st=%b cnt=%0d want 01 1", state0, cnt0); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_alternate();
        test_invalid();
        test_gap();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
